// File: rtl/deck_shuffler_pkg.sv
// Shared constants, FSM state type and small helpers for the deck shuffler.
package deck_shuffler_pkg;

    localparam int DECK_SIZE = 52;
    localparam int LAST_IDX  = 51;
    localparam int CARD_W    = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SWAP_RD = 3'd2,
        SWAP_WR = 3'd3,
        FIN     = 3'd4
    } state_t;

    function automatic logic in_deck(input logic [CARD_W-1:0] idx);
        return idx < CARD_W'(DECK_SIZE);
    endfunction

endpackage

// File: rtl/deck_shuffler_if.sv
// Bus between the deck shuffler, the index mapper above it and the dealer.
interface deck_shuffler_if #(
    parameter int CNT_W = 12
);
    import deck_shuffler_pkg::*;

    // start is a one-cycle request taken only while idle; busy covers the
    // whole pass and done pulses for one cycle when the deck is ready.
    logic                start;
    logic [CNT_W-1:0]    count;
    logic [CARD_W-1:0]   addr_i;
    logic [CARD_W-1:0]   addr_j;
    logic                busy;
    logic                done;
    logic [CARD_W-1:0]   rd_addr;
    logic [CARD_W-1:0]   rd_card;
    state_t              dbg_state;

    modport master (
        output start, addr_j, rd_addr,
        input  count, addr_i, busy, done, rd_card, dbg_state
    );

    modport slave (
        input  start, addr_j, rd_addr,
        output count, addr_i, busy, done, rd_card, dbg_state
    );

endinterface

// File: rtl/deck_shuffler_ram.sv
// 52-entry card store: two combinational swap reads, dual write, and a
// registered dealer read port. Resets to the identity deck.
module deck_ram
    import deck_shuffler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CARD_W-1:0] i_ra_addr,
    output logic [CARD_W-1:0] o_ra_data,
    input  logic [CARD_W-1:0] i_rb_addr,
    output logic [CARD_W-1:0] o_rb_data,
    input  logic              i_we1,
    input  logic [CARD_W-1:0] i_wa1,
    input  logic [CARD_W-1:0] i_wd1,
    input  logic              i_we2,
    input  logic [CARD_W-1:0] i_wa2,
    input  logic [CARD_W-1:0] i_wd2,
    input  logic [CARD_W-1:0] i_rd_addr,
    output logic [CARD_W-1:0] o_rd_card
);

    logic [CARD_W-1:0] r_mem [DECK_SIZE];
    logic [CARD_W-1:0] r_rd_card;

    assign o_ra_data = in_deck(i_ra_addr) ? r_mem[i_ra_addr] : '0;
    assign o_rb_data = in_deck(i_rb_addr) ? r_mem[i_rb_addr] : '0;
    assign o_rd_card = r_rd_card;

    // Port 2 is applied after port 1, so a self-swap leaves the entry intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DECK_SIZE; k++) begin
                r_mem[k] <= CARD_W'(k);
            end
            r_rd_card <= '0;
        end else begin
            for (int k = 0; k < DECK_SIZE; k++) begin
                if (i_we1 && (i_wa1 == CARD_W'(k))) begin
                    r_mem[k] <= i_wd1;
                end
                if (i_we2 && (i_wa2 == CARD_W'(k))) begin
                    r_mem[k] <= i_wd2;
                end
            end
            r_rd_card <= in_deck(i_rd_addr) ? r_mem[i_rd_addr] : '0;
        end
    end

endmodule

// File: rtl/deck_shuffler.sv
// Shuffle controller: re-initialises the deck, then sweeps i = 0..51 swapping
// deck[i] with the partner index returned by the external mapper.
module deck_shuffler
    import deck_shuffler_pkg::*;
#(
    parameter int               CNT_W   = 12,
    parameter logic [CNT_W-1:0] CNT_RST = '0
) (
    input  logic            clk,
    input  logic            rst,
    deck_shuffler_if.slave  bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CARD_W-1:0] r_idx;
    logic [CARD_W-1:0] w_idx_nxt;
    logic [CARD_W-1:0] r_j;
    logic [CARD_W-1:0] w_j_nxt;
    logic [CARD_W-1:0] r_a;
    logic [CARD_W-1:0] w_a_nxt;
    logic [CARD_W-1:0] r_b;
    logic [CARD_W-1:0] w_b_nxt;
    logic [CNT_W-1:0]  r_count;

    logic [CARD_W-1:0] w_j_sel;
    logic [CARD_W-1:0] w_ra_data;
    logic [CARD_W-1:0] w_rb_data;
    logic              w_we1;
    logic [CARD_W-1:0] w_wa1;
    logic [CARD_W-1:0] w_wd1;
    logic              w_we2;
    logic [CARD_W-1:0] w_wa2;
    logic [CARD_W-1:0] w_wd2;
    logic              w_swapping;
    logic              w_last;

    // An out-of-range partner degenerates to a self-swap.
    assign w_j_sel    = in_deck(bus.addr_j) ? bus.addr_j : r_idx;
    assign w_swapping = (r_state == SWAP_RD) || (r_state == SWAP_WR);
    assign w_last     = (r_idx == CARD_W'(LAST_IDX));

    assign bus.count     = r_count;
    assign bus.addr_i    = w_swapping ? r_idx : '0;
    assign bus.busy      = (r_state == INIT) || w_swapping;
    assign bus.done      = (r_state == FIN);
    assign bus.dbg_state = r_state;

    deck_ram u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_ra_addr (r_idx),
        .o_ra_data (w_ra_data),
        .i_rb_addr (w_j_sel),
        .o_rb_data (w_rb_data),
        .i_we1     (w_we1),
        .i_wa1     (w_wa1),
        .i_wd1     (w_wd1),
        .i_we2     (w_we2),
        .i_wa2     (w_wa2),
        .i_wd2     (w_wd2),
        .i_rd_addr (bus.rd_addr),
        .o_rd_card (bus.rd_card)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= CNT_RST;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_j     <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_j     <= w_j_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_j_nxt     = r_j;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_we1       = 1'b0;
        w_wa1       = '0;
        w_wd1       = '0;
        w_we2       = 1'b0;
        w_wa2       = '0;
        w_wd2       = '0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = INIT;
                    w_idx_nxt   = '0;
                end
            end
            INIT: begin
                w_we1 = 1'b1;
                w_wa1 = r_idx;
                w_wd1 = r_idx;
                if (w_last) begin
                    w_state_nxt = SWAP_RD;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            SWAP_RD: begin
                w_j_nxt     = w_j_sel;
                w_a_nxt     = w_ra_data;
                w_b_nxt     = w_rb_data;
                w_state_nxt = SWAP_WR;
            end
            SWAP_WR: begin
                w_we1 = 1'b1;
                w_wa1 = r_idx;
                w_wd1 = r_b;
                w_we2 = 1'b1;
                w_wa2 = r_j;
                w_wd2 = r_a;
                if (w_last) begin
                    w_state_nxt = FIN;
                    w_idx_nxt   = '0;
                end else begin
                    w_state_nxt = SWAP_RD;
                    w_idx_nxt   = r_idx + 1'b1;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: doc/deck_shuffler.md
Name: deck_shuffler

Overview:
- Owns the 52-entry card deck (6-bit card codes 0..51) and runs the shuffle pass that the next-address shuffle-index logic serves.
- Drives the sweep index `addr_i` and the free-running 12-bit `count` into that combinational index mapper, and takes back the partner index `addr_j`.
- Performs one swap of `deck[addr_i]` and `deck[addr_j]` per index, for i = 0..51.
- Gives the downstream dealer a synchronous read port into the shuffled deck.

Parameters:
- DECK_SIZE, 52, number of cards; fixed in this design and not to be overridden.
- CNT_W, 12, width of the free-running entropy counter.
- CNT_RST, 12'h000, value loaded into the entropy counter at reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request to (re)shuffle; sampled only in IDLE.
- count  out  12  free-running counter value, fed to the index mapper.
- addr_i  out  6  current sweep index, fed to the index mapper; 0 when not shuffling.
- addr_j  in  6  partner index from the mapper; combinational function of `addr_i` and `count`.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse when the shuffle completes.
- rd_addr  in  6  dealer read address.
- rd_card  out  6  card code at `rd_addr`, registered.

Behaviour:
- Reset (asynchronous): state=IDLE, count=CNT_RST, addr_i=0, busy=0, done=0, rd_card=0, deck[k]=k for all k.
- count: increments by 1 every clock in every state, with wrap 4095->0. Shuffle entropy comes from the `start` timing.
- States: IDLE, INIT, SWAP_RD, SWAP_WR, FIN.
- IDLE: if `start`=1 -> INIT with k=0 and busy=1. `start` in any other state is ignored.
- INIT: write deck[k]=k, k++; after the k=51 write -> SWAP_RD with addr_i=0. Takes 52 cycles.
- SWAP_RD (one cycle):
  - latch j = addr_j if addr_j<52, else j = addr_i (out-of-range partner means no swap);
  - latch a = deck[addr_i] and b = deck[j].
  - j is taken from the `addr_j` value present in this cycle, i.e. with the current `count`.
- SWAP_WR (one cycle):
  - write deck[addr_i]=b, then deck[j]=a; when j==addr_i the entry is unchanged.
  - if addr_i==51 -> FIN, else addr_i++ and -> SWAP_RD.
- FIN: done=1 for exactly this cycle, busy=0, addr_i=0 -> IDLE.
- Latency: `start` seen in cycle T -> INIT runs T+1..T+52 -> swaps run T+53..T+156 (2 cycles per index) -> done high in cycle T+157.
- Result: the deck is always a permutation of 0..51 for any `addr_j` sequence.
- Read port:
  - rd_card <= deck[rd_addr] each clock, 1-cycle latency, available in every state.
  - During a shuffle it returns in-progress contents; the dealer waits for `done`.
  - rd_addr>=52 -> rd_card=0.
- A read of an entry in the same cycle it is written returns the old value (no write-through).
- rst asserted mid-shuffle: immediate return to IDLE with the identity deck; no `done` pulse.

Decomposition:
- Shared package: DECK_SIZE=52, LAST_IDX=51, CARD_W=6, and the state enum {IDLE, INIT, SWAP_RD, SWAP_WR, FIN}.
- Natural sub-module: deck_ram (52x6 register array, one synchronous read port for the dealer, dual write used by SWAP_WR, reset to identity).
- The controller FSM and the entropy counter stay in deck_shuffler.
- The index mapper is instantiated at the level above, not inside this block.

Test Plan:
- Reset, then rd_addr=5, 17, 51 on consecutive cycles -> rd_card=5, 17, 51 each one cycle later; count increments 0,1,2,...
- Bench drives addr_j=51 constantly; pulse start in cycle T -> busy=1 from T+1, done=1 only in T+157. Expected final deck: deck[0]=51, deck[k]=k-1 for k=1..51.
- Bench drives addr_j=addr_i, and separately addr_j=63 (out of range) -> after done, deck[k]=k for all k (no swaps).
- Bench uses a behavioural model of the mapper with random `start` times, 20 runs -> every run yields 52 distinct codes 0..51, and done-to-start spacing is exactly 157 cycles.
- Pulse start while busy (e.g. T+40) -> ignored, done still at T+157, exactly one `done` pulse. Then assert rst at T+100 of a second shuffle -> busy=0 and done=0 immediately, deck reads back identity.
